stream_pattern_tx: RTL and testbench

Parametrised periodic pattern generator for the NAP data-stream fabric. It emits one `DATA_W`-bit beat every programmable interval, with a selectable pattern mode. Destinations rotate round-robin across `NUM_DEST` consecutive NAP addresses. It sits on a `t_DATA_STREAM.tx` port and drives LED or receiver demo endpoints, as well as traffic-test endpoints, elsewhere in the design.

---
 rtl/stream_pattern_tx_if.sv | 20 ++
 rtl/stream_pattern_tx.sv | 192 +++++++++++++++++++
 tb/tb_stream_pattern_tx.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pattern_tx_if.sv
// t_DATA_STREAM: NAP data-stream beat channel (data/addr/valid from the
// transmitter, ready from the receiver).
//   data  [DATA_W] beat payload
//   addr  [4]      NAP destination address
//   valid          beat presented
//   ready          receiver accepts the beat
// Modports: tx/master drive the beat, rx/slave consume it.
interface t_DATA_STREAM #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic [3:0]        addr;
  logic              valid;
  logic              ready;

  modport tx     (output data, output addr, output valid, input ready);
  modport rx     (input data, input addr, input valid, output ready);
  modport master (output data, output addr, output valid, input ready);
  modport slave  (input data, input addr, input valid, output ready);
endinterface

// File: rtl/stream_pattern_tx.sv
// stream_pattern_tx: periodic pattern generator for the NAP data stream.
// Emits one DATA_W-bit beat per programmable interval (walking-one,
// increment or fixed pattern) and rotates the destination round-robin over
// NUM_DEST consecutive NAP addresses starting at dest_base.
//   clk, resetn       clock, synchronous active-low reset
//   enable            run/stop (sampled in IDLE and at beat completion)
//   period            countdown cycles between beats
//   mode              0 walking-one, 1 increment, 2 fixed, 3 as 0
//   fixed_data        beat value in mode 2
//   dest_base         first destination address
//   beats_sent        completed handshakes (wrapping)
//   timeout_cnt       dropped beats (saturating, 0 when timeout disabled)
//   busy              state is not IDLE
//   nap               t_DATA_STREAM.tx beat channel
// Build option: define STREAM_TX_TIMEOUT_EN to drop a beat after
// TIMEOUT_CYC cycles of ready=0.
module stream_pattern_tx #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_DEST    = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [31:0]       period,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fixed_data,
  input  logic [3:0]        dest_base,
  output logic [31:0]       beats_sent,
  output logic [15:0]       timeout_cnt,
  output logic              busy,
  t_DATA_STREAM.tx          nap
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned TO_W  = 16;

  if (NUM_DEST < 1 || NUM_DEST > 16 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("stream_pattern_tx: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t              state_q,   state_d;
  logic [DATA_W-1:0]   pattern_q, pattern_d;
  logic [DATA_W-1:0]   data_q,    data_d;
  logic [3:0]          addr_q,    addr_d;
  logic                valid_q,   valid_d;
  logic [IDX_W-1:0]    dest_idx_q, dest_idx_d;
  logic [CNT_W-1:0]    count_q,   count_d;
  logic [CNT_W-1:0]    beats_q,   beats_d;
  logic                busy_q,    busy_d;
  logic [DATA_W-1:0]   next_pat;
  logic [DATA_W-1:0]   shifted;
  logic                beat_done;
`ifdef STREAM_TX_TIMEOUT_EN
  logic [CNT_W-1:0]    wait_q,    wait_d;
  logic [TO_W-1:0]     tocnt_q,   tocnt_d;
  logic                to_hit;
`endif

  assign nap.data    = data_q;
  assign nap.addr    = addr_q;
  assign nap.valid   = valid_q;
  assign beats_sent  = beats_q;
  assign busy        = busy_q;
`ifdef STREAM_TX_TIMEOUT_EN
  assign timeout_cnt = tocnt_q;
`else
  assign timeout_cnt = TO_W'(0);
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      pattern_q  <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      dest_idx_q <= '0;
      count_q    <= '0;
      beats_q    <= '0;
      busy_q     <= 1'b0;
`ifdef STREAM_TX_TIMEOUT_EN
      wait_q     <= '0;
      tocnt_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      dest_idx_q <= dest_idx_d;
      count_q    <= count_d;
      beats_q    <= beats_d;
      busy_q     <= busy_d;
`ifdef STREAM_TX_TIMEOUT_EN
      wait_q     <= wait_d;
      tocnt_q    <= tocnt_d;
`endif
    end
  end

  // Next pattern; the register is shared so a mode change continues from it
  always_comb begin
    shifted  = pattern_q << 1;
    next_pat = pattern_q;
    case (mode)
      2'd1:    next_pat = pattern_q + DATA_W'(1);
      2'd2:    next_pat = fixed_data;
      default: next_pat = (shifted == '0) ? DATA_W'(1) : shifted;
    endcase
  end

  // Next-state and register updates
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    data_d     = data_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    dest_idx_d = dest_idx_q;
    count_d    = count_q;
    beats_d    = beats_q;
    beat_done  = 1'b0;
`ifdef STREAM_TX_TIMEOUT_EN
    wait_d     = wait_q;
    tocnt_d    = tocnt_q;
    to_hit     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          count_d = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (count_q != '0) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          pattern_d = next_pat;
          data_d    = next_pat;
          addr_d    = dest_base + dest_idx_q;
          valid_d   = 1'b1;
          state_d   = ST_SEND;
`ifdef STREAM_TX_TIMEOUT_EN
          wait_d    = '0;
`endif
        end
      end

      ST_SEND: begin
        // A handshake on the timeout cycle wins over the timeout
        if (nap.ready) begin
          beat_done = 1'b1;
          beats_d   = beats_q + CNT_W'(1);
        end
`ifdef STREAM_TX_TIMEOUT_EN
        else if (wait_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          to_hit    = 1'b1;
          beat_done = 1'b1;
          if (tocnt_q != {TO_W{1'b1}}) tocnt_d = tocnt_q + TO_W'(1);
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
`endif
        if (beat_done) begin
          valid_d    = 1'b0;
          dest_idx_d = (dest_idx_q == IDX_W'(NUM_DEST - 1)) ? '0
                                                            : dest_idx_q + IDX_W'(1);
          count_d    = period;
          state_d    = enable ? ST_WAIT : ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_stream_pattern_tx.sv
// tb_stream_pattern_tx: directed self-checking bench for stream_pattern_tx
// (DATA_W=8, NUM_DEST=4, TIMEOUT_CYC=16).
module tb_stream_pattern_tx;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic [31:0] period;
  logic [1:0]  mode;
  logic [7:0]  fixed_data;
  logic [3:0]  dest_base;
  logic [31:0] beats_sent;
  logic [15:0] timeout_cnt;
  logic        busy;

  int errors;
  int checks;
  int cyc;

  t_DATA_STREAM #(.DATA_W(8)) nap ();

  stream_pattern_tx #(
    .DATA_W(8),
    .NUM_DEST(4),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .period(period),
    .mode(mode),
    .fixed_data(fixed_data),
    .dest_base(dest_base),
    .beats_sent(beats_sent),
    .timeout_cnt(timeout_cnt),
    .busy(busy),
    .nap(nap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Bounded wait for valid; an expired bound is a failed comparison
  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (nap.valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: valid not seen within 40 cycles", name);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    checks++;
    if ({nap.valid, nap.data, nap.addr, busy} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h addr=%h busy=%b, need all 0",
               nap.valid, nap.data, nap.addr, busy);
    end
    checks++;
    if (beats_sent !== 32'd0 || timeout_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: beats=%0d timeouts=%0d, need 0/0", beats_sent, timeout_cnt);
    end
    resetn = 1'b1;
  endtask

  task automatic test_walking_one();
    logic [7:0] exp_data [9];
    logic [3:0] exp_addr [9];
    int  last_rise;
    bit  ok;
    exp_data = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    exp_addr = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd2, 4'd3, 4'd4, 4'd5, 4'd2};
    mode = 2'd0; period = 32'd3; dest_base = 4'd2; nap.ready = 1'b1;
    enable = 1'b1;
    tick();
    checks++;
    if (nap.valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_latency_a: valid=%b busy=%b, need 0/1", nap.valid, busy);
    end
    tick();
    checks++;
    if (nap.valid !== 1'b1) begin
      errors++;
      $display("FAIL first_latency_b: valid=%b, need 1", nap.valid);
    end
    last_rise = cyc;
    for (int b = 0; b < 9; b++) begin
      if (b > 0) begin
        wait_valid("walk_valid", ok);
        checks++;
        if (cyc - last_rise !== 5) begin
          errors++;
          $display("FAIL walk_gap[%0d]: got %0d cycles, need 5", b, cyc - last_rise);
        end
        last_rise = cyc;
      end
      checks++;
      if (nap.data !== exp_data[b] || nap.addr !== exp_addr[b]) begin
        errors++;
        $display("FAIL walk_beat[%0d]: data=%h addr=%0d, need data=%h addr=%0d",
                 b, nap.data, nap.addr, exp_data[b], exp_addr[b]);
      end
      if (b == 8) enable = 1'b0;
      tick();
    end
    checks++;
    if (beats_sent !== 32'd9) begin
      errors++;
      $display("FAIL walk_beats: got %0d, need 9", beats_sent);
    end
    checks++;
    if (nap.valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL walk_stop: valid=%b busy=%b, need 0/0", nap.valid, busy);
    end
  endtask

  // dest_idx is 1 here (9 beats, 4 destinations); fixed mode makes data known
  task automatic test_backpressure();
    localparam int HOLD = 20;
    bit ok;
    int t_hs;
    mode = 2'd2; fixed_data = 8'hA5; period = 32'd2; nap.ready = 1'b0;
    enable = 1'b1;
    wait_valid("bp_valid", ok);
    checks++;
    if (nap.data !== 8'hA5 || nap.addr !== 4'd3) begin
      errors++;
      $display("FAIL bp_beat: data=%h addr=%0d, need A5/3", nap.data, nap.addr);
    end
`ifdef STREAM_TX_TIMEOUT_EN
    for (int i = 0; i < 10; i++) begin
`else
    for (int i = 0; i < HOLD; i++) begin
`endif
      tick();
      checks++;
      if (nap.valid !== 1'b1 || nap.data !== 8'hA5 || nap.addr !== 4'd3) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h addr=%0d, need 1/A5/3",
                 i, nap.valid, nap.data, nap.addr);
      end
    end
    nap.ready = 1'b1;
    t_hs = cyc;
    tick();
    checks++;
    if (nap.valid !== 1'b0 || beats_sent !== 32'd10) begin
      errors++;
      $display("FAIL bp_handshake: valid=%b beats=%0d, need 0/10", nap.valid, beats_sent);
    end
    wait_valid("bp_next", ok);
    checks++;
    if (cyc - t_hs !== 4) begin
      errors++;
      $display("FAIL bp_next_gap: got %0d cycles, need 4", cyc - t_hs);
    end
    checks++;
    if (nap.addr !== 4'd4) begin
      errors++;
      $display("FAIL bp_next_addr: got %0d, need 4", nap.addr);
    end
  endtask

  // Entered with a beat pending (valid=1)
  task automatic test_stop_during_send();
    int highs;
    nap.ready = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (nap.valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stop_hold: valid=%b busy=%b, need 1/1", nap.valid, busy);
    end
    nap.ready = 1'b1;
    tick();
    checks++;
    if (nap.valid !== 1'b0 || busy !== 1'b0 || beats_sent !== 32'd11) begin
      errors++;
      $display("FAIL stop_done: valid=%b busy=%b beats=%0d, need 0/0/11",
               nap.valid, busy, beats_sent);
    end
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (nap.valid === 1'b1) highs++;
    end
    checks++;
    if (highs !== 0) begin
      errors++;
      $display("FAIL stop_quiet: valid high %0d cycles, need 0", highs);
    end
  endtask

  // dest_idx is 3 here
  task automatic test_increment_wrap();
    logic [7:0] exp_data [3];
    logic [3:0] exp_addr [3];
    bit ok;
    exp_data = '{8'hFE, 8'hFF, 8'h00};
    exp_addr = '{4'd5, 4'd2, 4'd3};
    mode = 2'd2; fixed_data = 8'hFE; period = 32'd0; nap.ready = 1'b1;
    enable = 1'b1;
    for (int b = 0; b < 3; b++) begin
      wait_valid("inc_valid", ok);
      checks++;
      if (nap.data !== exp_data[b] || nap.addr !== exp_addr[b]) begin
        errors++;
        $display("FAIL inc_beat[%0d]: data=%h addr=%0d, need data=%h addr=%0d",
                 b, nap.data, nap.addr, exp_data[b], exp_addr[b]);
      end
      mode = 2'd1;
      if (b == 2) enable = 1'b0;
      tick();
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int highs;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    mode = 2'd0; period = 32'd1; dest_base = 4'd6; nap.ready = 1'b0;
    enable = 1'b1;
    wait_valid("to_valid", ok);
    checks++;
    if (nap.data !== 8'h01 || nap.addr !== 4'd6) begin
      errors++;
      $display("FAIL to_first: data=%h addr=%0d, need 01/6", nap.data, nap.addr);
    end
`ifdef STREAM_TX_TIMEOUT_EN
    highs = 0;
    for (int i = 0; i < 40 && nap.valid === 1'b1; i++) begin
      highs++;
      tick();
    end
    checks++;
    if (highs !== 16) begin
      errors++;
      $display("FAIL to_length: valid high %0d cycles, need 16", highs);
    end
    checks++;
    if (timeout_cnt !== 16'd1 || beats_sent !== 32'd0) begin
      errors++;
      $display("FAIL to_counters: timeouts=%0d beats=%0d, need 1/0", timeout_cnt, beats_sent);
    end
    nap.ready = 1'b1;
    wait_valid("to_next", ok);
    checks++;
    if (nap.data !== 8'h02 || nap.addr !== 4'd7) begin
      errors++;
      $display("FAIL to_next: data=%h addr=%0d, need 02/7", nap.data, nap.addr);
    end
`else
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (nap.valid === 1'b1) highs++;
    end
    checks++;
    if (highs !== 40 || timeout_cnt !== 16'd0) begin
      errors++;
      $display("FAIL to_disabled: valid high %0d of 40, timeouts=%0d, need 40/0",
               highs, timeout_cnt);
    end
    nap.ready = 1'b1;
`endif
    enable = 1'b0;
    tick();
    checks++;
    if (nap.valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_stop: valid=%b busy=%b, need 0/0", nap.valid, busy);
    end
  endtask

  task automatic test_reset_mid_send();
    bit ok;
    mode = 2'd0; period = 32'd2; dest_base = 4'd9; nap.ready = 1'b0;
    enable = 1'b1;
    tick();
    wait_valid("rst_valid", ok);
    resetn = 1'b0;
    tick();
    checks++;
    if ({nap.valid, nap.data, nap.addr, busy} !== 14'd0 ||
        beats_sent !== 32'd0 || timeout_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid: valid=%b data=%h addr=%h busy=%b beats=%0d timeouts=%0d, need all 0",
               nap.valid, nap.data, nap.addr, busy, beats_sent, timeout_cnt);
    end
    resetn = 1'b1;
    nap.ready = 1'b1;
    tick();
    tick();
    checks++;
    if (nap.valid !== 1'b1 || nap.data !== 8'h01 || nap.addr !== 4'd9) begin
      errors++;
      $display("FAIL rst_restart: valid=%b data=%h addr=%0d, need 1/01/9",
               nap.valid, nap.data, nap.addr);
    end
    enable = 1'b0;
    tick();
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    resetn = 1'b0; enable = 1'b0; period = '0; mode = '0;
    fixed_data = '0; dest_base = '0; nap.ready = 1'b0;
    test_reset();
    test_walking_one();
    test_backpressure();
    test_stop_during_send();
    test_increment_wrap();
    test_timeout();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
